mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the pipeline's instruction fetch (IF) port and data (MEM) port.
- Arbitrates the two requests and sequences each access over MEM_LATENCY cycles.
- Returns read data to the winning requester and drives per-port stall signals to the hazard/stall logic.
- Sits between the pipelined datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency single-port memory between the
// instruction-fetch port and the data port. Each granted access occupies the
// memory for MEM_LATENCY cycles. Ties alternate so that neither port starves.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WORD_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WORD_WIDTH-1:0] i_data,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WORD_WIDTH-1:0] m_wdata,
  input  logic [WORD_WIDTH-1:0] m_rdata,
  output logic                  grant_d
);

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant_d;  // 1 when the previous winner was the data port
  logic             we_lat;
  logic             any_req;
  logic             win_d;
  logic             final_cycle;

  // Winner selection: data wins a tie unless it won the previous access.
  always_comb begin
    any_req     = i_req | d_req;
    win_d       = d_req & (~i_req | ~last_grant_d);
    final_cycle = (state == BUSY) && (cnt == '0);
  end

  // Completion pulses, returned data and stalls are decoded from the FSM so
  // they appear in the final access cycle and vanish at once on reset.
  always_comb begin
    i_ready   = final_cycle & ~grant_d;
    d_ready   = final_cycle & grant_d;
    i_data    = i_ready ? m_rdata : '0;
    d_rdata   = (d_ready && !we_lat) ? m_rdata : '0;
    stall_if  = i_req & ~i_ready;
    stall_mem = d_req & ~d_ready;
  end

  // Access sequencer: latch the winner in IDLE, count the access down in BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant_d <= 1'b0;
      we_lat       <= 1'b0;
      grant_d      <= 1'b0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            m_addr       <= win_d ? d_addr : i_addr;
            if (win_d && d_we) begin
              m_wdata <= d_wdata;
            end
            we_lat       <= win_d & d_we;
            grant_d      <= win_d;
            last_grant_d <= win_d;
            m_read       <= ~(win_d & d_we);
            m_write      <= win_d & d_we;
            cnt          <= CNT_LOAD;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            // Final cycle: release the memory; one IDLE cycle follows.
            m_read  <= 1'b0;
            m_write <= 1'b0;
            grant_d <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a cycle-level model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int WW = 16;
  localparam int L  = 2;

  logic          clk;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [WW-1:0] i_data;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [WW-1:0] d_wdata;
  logic [WW-1:0] d_rdata;
  logic          d_ready;
  logic          stall_if;
  logic          stall_mem;
  logic          m_read;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wdata;
  logic [WW-1:0] m_rdata;
  logic          grant_d;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic we, input logic [AW-1:0] da,
                       input logic [WW-1:0] wd, input logic [WW-1:0] rd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da;
    d_wdata = wd; m_rdata = rd;
  endtask

  // Leaves the bench at the start of cycle 0 with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          we;
    logic [AW-1:0] da;
    logic [WW-1:0] wd;
    logic [WW-1:0] rd;
    logic          e_ir;
    logic          e_dr;
    logic          e_mr;
    logic          e_mw;
    logic          e_gd;
    logic [AW-1:0] e_ma;
    logic [WW-1:0] e_mwd;
    logic [WW-1:0] e_id;
    logic [WW-1:0] e_dd;
  } vec_t;

  vec_t vec[12];

  // Reference model state (cycle-numbered, not FSM-encoded).
  int            cyc;
  int            busy_until;
  logic          mdl_last_d;
  logic          mdl_win_d;
  logic          mdl_we;
  logic [AW-1:0] mdl_addr;
  logic [WW-1:0] mdl_wdata;

  task automatic model_reset();
    cyc = 0; busy_until = -1; mdl_last_d = 0; mdl_win_d = 0; mdl_we = 0;
    mdl_addr = '0; mdl_wdata = '0;
  endtask

  // Compare the current cycle against the model, then let the model arbitrate.
  task automatic model_step();
    logic busy, rdy, e_ir, e_dr;
    busy = (cyc <= busy_until);
    rdy  = busy && (cyc == busy_until);
    e_ir = rdy && !mdl_win_d;
    e_dr = rdy && mdl_win_d;
    chk("rnd_i_ready", i_ready, e_ir);
    chk("rnd_d_ready", d_ready, e_dr);
    chk("rnd_m_read", m_read, busy && !mdl_we);
    chk("rnd_m_write", m_write, busy && mdl_we);
    chk("rnd_grant_d", grant_d, busy && mdl_win_d);
    chk("rnd_m_addr", m_addr, mdl_addr);
    chk("rnd_m_wdata", m_wdata, mdl_wdata);
    chk("rnd_i_data", i_data, e_ir ? m_rdata : '0);
    chk("rnd_d_rdata", d_rdata, (e_dr && !mdl_we) ? m_rdata : '0);
    chk("rnd_stall_if", stall_if, i_req && !e_ir);
    chk("rnd_stall_mem", stall_mem, d_req && !e_dr);
    if (!busy && (i_req || d_req)) begin
      mdl_win_d  = d_req && (!i_req || !mdl_last_d);
      mdl_last_d = mdl_win_d;
      mdl_we     = mdl_win_d && d_we;
      mdl_addr   = mdl_win_d ? d_addr : i_addr;
      if (mdl_we) mdl_wdata = d_wdata;
      busy_until = cyc + L;
    end
    cyc++;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Single fetch, data write with late wdata change, data read.
    vec[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vec[1]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000};
    vec[2]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, 1, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'hA5A5, 16'h0000};
    vec[3]  = '{0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000};
    vec[4]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000};
    vec[5]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 1, 16'h0200, 16'h1234, 16'h0000, 16'h0000};
    vec[6]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'hFFFF, 16'hBEEF, 0, 1, 0, 1, 1, 16'h0200, 16'h1234, 16'h0000, 16'h0000};
    vec[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0200, 16'h1234, 16'h0000, 16'h0000};
    vec[8]  = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0200, 16'h1234, 16'h0000, 16'h0000};
    vec[9]  = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h0000, 0, 0, 1, 0, 1, 16'h0300, 16'h1234, 16'h0000, 16'h0000};
    vec[10] = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h5A5A, 0, 1, 1, 0, 1, 16'h0300, 16'h1234, 16'h0000, 16'h5A5A};
    vec[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0300, 16'h1234, 16'h0000, 16'h0000};

    do_reset();
    @(negedge clk);
    chk("rst_m_read", m_read, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_m_addr", m_addr, 0);
    tick();

    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(vec[k].ir, vec[k].ia, vec[k].dr, vec[k].we, vec[k].da, vec[k].wd, vec[k].rd);
      @(negedge clk);
      chk($sformatf("vec%0d_i_ready", k), i_ready, vec[k].e_ir);
      chk($sformatf("vec%0d_d_ready", k), d_ready, vec[k].e_dr);
      chk($sformatf("vec%0d_m_read", k), m_read, vec[k].e_mr);
      chk($sformatf("vec%0d_m_write", k), m_write, vec[k].e_mw);
      chk($sformatf("vec%0d_grant_d", k), grant_d, vec[k].e_gd);
      chk($sformatf("vec%0d_m_addr", k), m_addr, vec[k].e_ma);
      chk($sformatf("vec%0d_m_wdata", k), m_wdata, vec[k].e_mwd);
      chk($sformatf("vec%0d_i_data", k), i_data, vec[k].e_id);
      chk($sformatf("vec%0d_d_rdata", k), d_rdata, vec[k].e_dd);
      chk($sformatf("vec%0d_stall_if", k), stall_if, vec[k].ir && !vec[k].e_ir);
      chk($sformatf("vec%0d_stall_mem", k), stall_mem, vec[k].dr && !vec[k].e_dr);
      tick();
    end

    // Tie from reset and sustained contention: D at 2, I at 5, D at 8, I at 11.
    do_reset();
    drive(1, 16'h0004, 1, 0, 16'h0100, 16'h0000, 16'h0000);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_d_ready", c), d_ready, (c == 2 || c == 8));
      chk($sformatf("cont%0d_i_ready", c), i_ready, (c == 5 || c == 11));
      chk($sformatf("cont%0d_grant_d", c), grant_d, (c == 1 || c == 2 || c == 7 || c == 8));
      if (c == 1 || c == 2) chk($sformatf("cont%0d_m_addr", c), m_addr, 16'h0100);
      if (c == 4 || c == 5) chk($sformatf("cont%0d_m_addr", c), m_addr, 16'h0004);
      tick();
    end
    tick();
    chk("cont13_busy_grant_d", grant_d, 1);
    // Asynchronous reset with both requests held.
    reset_n = 1'b0;
    #1;
    chk("arst_m_read", m_read, 0);
    chk("arst_m_write", m_write, 0);
    chk("arst_grant_d", grant_d, 0);
    chk("arst_ready", {i_ready, d_ready}, 0);
    chk("arst_m_addr", m_addr, 0);
    chk("arst_m_wdata", m_wdata, 0);
    chk("arst_data", {i_data, d_rdata}, 0);
    chk("arst_stall_if", stall_if, 1);
    chk("arst_stall_mem", stall_mem, 1);

    // Reset in the middle of a fetch, then re-grant after release.
    do_reset();
    drive(1, 16'h0030, 0, 0, 0, 0, 16'h7777);
    @(negedge clk);
    tick();
    chk("mid1_m_read_before", m_read, 1);
    reset_n = 1'b0;
    #1;
    chk("mid1_m_read_drop", m_read, 0);
    chk("mid1_i_ready", i_ready, 0);
    @(negedge clk);
    chk("mid1_i_ready_neg", i_ready, 0);
    tick();
    @(negedge clk);
    chk("mid2_i_ready", i_ready, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid3_m_read", m_read, 0);
    chk("mid3_i_ready", i_ready, 0);
    tick();
    @(negedge clk);
    chk("mid4_m_read", m_read, 1);
    chk("mid4_i_ready", i_ready, 0);
    tick();
    @(negedge clk);
    chk("mid5_i_ready", i_ready, 1);
    chk("mid5_i_data", i_data, 16'h7777);
    chk("mid5_m_addr", m_addr, 16'h0030);
    tick();

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 3) != 0,
            1'($urandom), AW'($urandom), WW'($urandom), WW'($urandom));
      @(negedge clk);
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
